reg_sequencer: RTL and testbench
================================

REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register and operand width.
REQ-002 SHALL have parameter ADDR_W, default 3: register address width (8 registers R0-R7).
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum number of EXEC cycles to wait for alu_done.
REQ-004 SHALL have port clk  in  1: single clock; all logic on posedge; one clock, no other clock domain.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port instr_valid  in  1: decoded instruction offered.
REQ-007 SHALL have port instr_ready  out  1: sequencer can accept an instruction.
REQ-008 SHALL have ports instr_rd, instr_rs1 and instr_rs2  in  ADDR_W each: destination and source register addresses.
REQ-009 SHALL have port instr_wb  in  1: instruction writes a result back.
REQ-010 SHALL have ports rf_raddr1 and rf_raddr2  out  ADDR_W each: register-file read addresses.
REQ-011 SHALL have ports rf_rdata1 and rf_rdata2  in  DATA_W each: register-file asynchronous read data.
REQ-012 SHALL have port rf_waddr  out  ADDR_W: register-file write address.
REQ-013 SHALL have port rf_wdata  out  DATA_W: register-file write data.
REQ-014 SHALL have port rf_we  out  1: register-file write enable.
REQ-015 SHALL have ports alu_a and alu_b  out  DATA_W each: captured operands.
REQ-016 SHALL have port alu_start  out  1: one-cycle pulse that starts the ALU.
REQ-017 SHALL have port alu_done  in  1: ALU result valid.
REQ-018 SHALL have port alu_result  in  DATA_W: ALU result.
REQ-019 SHALL have port busy  out  1: high whenever state is not IDLE.
REQ-020 SHALL have port err  out  1: one-cycle pulse on ALU timeout.

Function
REQ-021 SHALL implement a state machine with states IDLE, READ, EXEC and WB.
REQ-022 SHALL drive instr_ready=1 only in IDLE; a transfer is instr_valid&&instr_ready at a posedge.
REQ-023 SHALL, on a transfer, latch rd, rs1, rs2 and wb, and go IDLE->READ.
REQ-024 SHALL drive rf_raddr1/2 from the latched rs1/rs2 in READ, and hold them until the next accept.
REQ-025 SHALL, at the end of the single READ cycle, capture rf_rdata1/2 into alu_a/alu_b and go to EXEC.
REQ-026 SHALL assert alu_start for exactly the first EXEC cycle.
REQ-027 SHALL sample alu_done in every EXEC cycle, including the alu_start cycle.
REQ-028 SHALL, on alu_done, capture alu_result into rf_wdata; then go to WB if wb=1, else to IDLE.
REQ-029 SHALL ignore alu_done outside EXEC.
REQ-030 SHALL, in WB, assert rf_we for exactly one cycle with rf_waddr equal to the latched rd, then go to IDLE.
REQ-031 SHALL keep rf_we=0 in every state other than WB.
REQ-032 SHALL count EXEC cycles; if TIMEOUT cycles pass without alu_done, it SHALL pulse err for 1 cycle, go to IDLE and issue no write.
REQ-033 SHALL give this latency: accept at cycle 0, READ at 1, alu_start at 2, alu_done at cycle N≥2, rf_we at N+1, instr_ready=1 at N+2 (N+1 when wb=0).
REQ-034 SHALL take the write-then-read ordering from the single-issue FSM: an instruction accepted right after WB reads the already-written value, with no forwarding.
REQ-035 SHALL drive the TIMEOUT counter at ceil(log2(TIMEOUT+1)) bits, saturating with no wrap.

Reset
REQ-036 SHALL, while rst=1, force state to IDLE, instr_ready to 0, and busy, err, rf_we and alu_start to 0.
REQ-037 SHALL, while rst=1, force all address, operand and wdata registers to 0.
REQ-038 SHALL, when rst is asserted mid-operation in any state, abandon the instruction with no write issued; instr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-039 SHALL, when R0_ZERO_EN is defined, substitute 0 for any operand whose source address is 0, regardless of rf_rdata.
REQ-040 SHALL, when R0_ZERO_EN is defined, still enter WB for rd=0 but hold rf_we=0 throughout.
REQ-041 SHALL, when R0_ZERO_EN is undefined, treat R0 as an ordinary register.

Structure
REQ-042 SHALL place DATA_W/ADDR_W defaults and the state enum typedef in the shared package cpu_pkg.
REQ-043 SHALL implement the EXEC timeout counter as the single sub-module alu_timeout_counter, with ports clear, enable and expired.

Verification
REQ-044 SHALL verify: R1=0x05, R2=0x03, rd=3, rs1=1, rs2=2, wb=1, alu_done+0x08 at the 2nd EXEC cycle -> alu_a=0x05, alu_b=0x03, one rf_we with waddr=3, wdata=0x08.
REQ-045 SHALL verify: same instruction with wb=0 -> no rf_we, instr_ready back 1 cycle after alu_done.
REQ-046 SHALL verify: alu_done never asserted, TIMEOUT=16 -> err pulses once after 16 EXEC cycles, no rf_we, returns to IDLE.
REQ-047 SHALL verify: rst asserted during EXEC -> next cycle all outputs 0, no write; a new instruction is then accepted normally.
REQ-048 SHALL verify: back-to-back pair where instruction 2 reads the rd of instruction 1 -> instruction 2 operand equals instruction 1 result.
REQ-049 SHALL verify, with R0_ZERO_EN: rs1=0 while the register file holds 0xAA -> alu_a=0x00; rd=0 -> rf_we never asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared defaults and FSM state type for the register sequencer.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_ADDR_W  = 3;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

endpackage

// File: rtl/reg_sequencer_if.sv
// Instruction, register-file and ALU signals of the register sequencer.
// slave is the sequencer side; master is the environment side.
interface reg_sequencer_if import cpu_pkg::*; #(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic              instr_wb;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_start;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              err;

    modport slave (
        input  instr_valid, instr_rd, instr_rs1, instr_rs2, instr_wb,
        input  rf_rdata1, rf_rdata2, alu_done, alu_result,
        output instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        output alu_a, alu_b, alu_start, busy, err
    );

    modport master (
        output instr_valid, instr_rd, instr_rs1, instr_rs2, instr_wb,
        output rf_rdata1, rf_rdata2, alu_done, alu_result,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        input  alu_a, alu_b, alu_start, busy, err
    );

endinterface

// File: rtl/alu_timeout_counter.sv
// Saturating EXEC-cycle counter; expired flags the TIMEOUT-th enabled cycle.
module alu_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (clear) begin
            w_cnt_next = '0;
        end else if (enable && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // r_cnt holds the number of earlier EXEC cycles, so this fires on the last allowed one.
    assign expired = enable && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/reg_sequencer.sv
// Single-issue read/execute/write-back sequencer between a register file and an ALU.
// Optional R0_ZERO_EN: R0 reads as zero and writes to R0 are suppressed.
module reg_sequencer import cpu_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    reg_sequencer_if.slave bus
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic              r_wb;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_wdata;
    logic              r_first;
    logic              r_err;

    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic              w_expired;
    logic              w_wr_allow;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;

`ifdef R0_ZERO_EN
    assign w_opa      = (r_rs1 == '0) ? '0 : bus.rf_rdata1;
    assign w_opb      = (r_rs2 == '0) ? '0 : bus.rf_rdata2;
    assign w_wr_allow = (r_rd != '0);
`else
    assign w_opa      = bus.rf_rdata1;
    assign w_opb      = bus.rf_rdata2;
    assign w_wr_allow = 1'b1;
`endif

    alu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_alu_timeout_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state != StExec),
        .enable  (r_state == StExec),
        .expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.instr_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StRead;
                end
            end
            StRead: w_state_next = StExec;
            StExec: begin
                if (bus.alu_done) begin
                    w_done       = 1'b1;
                    w_state_next = r_wb ? StWb : StIdle;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StWb:    w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_wb    <= 1'b0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_wdata <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_first <= (r_state == StRead);
            r_err   <= w_timeout;
            if (w_accept) begin
                r_rd  <= bus.instr_rd;
                r_rs1 <= bus.instr_rs1;
                r_rs2 <= bus.instr_rs2;
                r_wb  <= bus.instr_wb;
            end
            if (r_state == StRead) begin
                r_alu_a <= w_opa;
                r_alu_b <= w_opb;
            end
            if (w_done) begin
                r_wdata <= bus.alu_result;
            end
        end
    end

    // Control outputs are gated by rst so they drop in the very cycle reset is raised.
    assign bus.instr_ready = (r_state == StIdle) && !rst;
    assign bus.busy        = (r_state != StIdle) && !rst;
    assign bus.alu_start   = (r_state == StExec) && r_first && !rst;
    assign bus.rf_we       = (r_state == StWb) && w_wr_allow && !rst;
    assign bus.err         = r_err && !rst;
    assign bus.rf_raddr1   = r_rs1;
    assign bus.rf_raddr2   = r_rs2;
    assign bus.rf_waddr    = r_rd;
    assign bus.rf_wdata    = r_wdata;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;

endmodule

// File: tb/tb_reg_sequencer.sv
// Scoreboard bench for reg_sequencer: directed instructions, register-file and ALU models.
module tb_reg_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_sequencer #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_ops[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_err[$];

    // Register file model with a preload port for the bench.
    logic [DW-1:0] rf [8];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    // ALU model: done alu_lat cycles after the alu_start cycle (0 = same cycle).
    int            alu_lat = 1;
    logic          alu_never = 1'b0;
    logic [DW-1:0] alu_res = '0;
    logic          stray_done = 1'b0;
    logic          alu_busy;
    int            ex_cnt = 0;
    always_comb begin
        bus.alu_done = stray_done;
        if (!alu_never && bus.busy) begin
            if (bus.alu_start && alu_lat == 0) bus.alu_done = 1'b1;
            if (alu_busy && ex_cnt == alu_lat) bus.alu_done = 1'b1;
        end
    end
    assign bus.alu_result = alu_res;
    always @(posedge clk) begin
        if (bus.alu_start) begin
            alu_busy <= 1'b1;
            ex_cnt   <= 1;
        end else if (alu_busy) begin
            ex_cnt <= ex_cnt + 1;
        end
        if ((bus.alu_done && !bus.alu_start) || !bus.busy) alu_busy <= 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (bus.alu_start) begin
            if (exp_ops.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_start: got a=0x%0h b=0x%0h, expected none",
                         bus.alu_a, bus.alu_b);
            end else begin
                check("operands", {16'h0, bus.alu_a, bus.alu_b}, exp_ops.pop_front());
            end
        end
        if (bus.rf_we) begin
            if (exp_wr.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected none",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                check("write", {21'h0, bus.rf_waddr, bus.rf_wdata}, exp_wr.pop_front());
            end
        end
        if (bus.err) begin
            if (exp_err.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_err: got err=1, expected 0");
            end else begin
                check("err", 32'(bus.err), exp_err.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step(1);
        pl_en = 1'b0;
    endtask

    // Returns one cycle after the accepting edge, i.e. in the READ cycle.
    task automatic issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic wb,
                         input logic [DW-1:0] res, input int lat);
        int t = 0;
        while (!bus.instr_ready && t < 200) begin
            step(1);
            t++;
        end
        check("ready_wait", 32'(bus.instr_ready), 32'd1);
        alu_res = res;
        alu_lat = lat;
        bus.instr_valid = 1'b1;
        bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2; bus.instr_wb = wb;
        step(1);
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_rd = '0; bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_wb = 1'b0;
        step(1);
        preload(3'd0, 8'hAA);
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);

        // Reset state
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_we", 32'(bus.rf_we), 32'd0);
        check("rst_start", 32'(bus.alu_start), 32'd0);
        check("rst_regs", {bus.alu_a, bus.alu_b, bus.rf_wdata, 2'b0, bus.rf_raddr1, bus.rf_waddr},
              32'h0);
        rst = 1'b0;
        step(1);
        check("idle_ready", 32'(bus.instr_ready), 32'd1);

        // R3 = R1 + R2 with done on the 2nd EXEC cycle
        exp_ops.push_back(32'h0503);
        exp_wr.push_back({21'h0, 3'd3, 8'h08});
        issue(3'd3, 3'd1, 3'd2, 1'b1, 8'h08, 1);
        check("read_busy", 32'(bus.busy), 32'd1);
        check("read_ready", 32'(bus.instr_ready), 32'd0);
        check("read_raddr", {bus.rf_raddr1, bus.rf_raddr2}, {26'h0, 3'd1, 3'd2});
        step(1);
        check("exec_start", 32'(bus.alu_start), 32'd1);
        step(1);
        check("exec2_start", 32'(bus.alu_start), 32'd0);
        step(1);
        check("wb_we", 32'(bus.rf_we), 32'd1);
        step(1);
        check("wb_ready", 32'(bus.instr_ready), 32'd1);
        check("after_wb_we", 32'(bus.rf_we), 32'd0);

        // Same instruction without write-back
        exp_ops.push_back(32'h0503);
        issue(3'd3, 3'd1, 3'd2, 1'b0, 8'h09, 1);
        step(3);
        check("nowb_ready", 32'(bus.instr_ready), 32'd1);
        check("nowb_we", 32'(bus.rf_we), 32'd0);
        check("nowb_wdata", 32'(bus.rf_wdata), 32'h09);

        // ALU never answers
        alu_never = 1'b1;
        exp_ops.push_back(32'h0503);
        exp_err.push_back(32'd1);
        issue(3'd6, 3'd1, 3'd2, 1'b1, 8'h55, 1);
        step(16);
        check("to_last_busy", 32'(bus.busy), 32'd1);
        check("to_last_err", 32'(bus.err), 32'd0);
        step(1);
        check("to_err", 32'(bus.err), 32'd1);
        check("to_idle", 32'(bus.instr_ready), 32'd1);
        step(1);
        check("to_err_pulse", 32'(bus.err), 32'd0);
        alu_never = 1'b0;

        // Reset during EXEC, then a fresh instruction with done on the start cycle
        exp_ops.push_back(32'h0503);
        issue(3'd7, 3'd1, 3'd2, 1'b1, 8'h77, 5);
        step(2);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        step(1);
        check("rst_mid_ctl", {bus.instr_ready, bus.busy, bus.err, bus.rf_we, bus.alu_start},
              32'h0);
        check("rst_mid_regs", {bus.alu_a, bus.alu_b, bus.rf_wdata, 2'b0, bus.rf_raddr1,
              bus.rf_waddr}, 32'h0);
        rst = 1'b0;
        step(1);
        check("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
        exp_ops.push_back(32'h0305);
        exp_wr.push_back({21'h0, 3'd7, 8'h2A});
        issue(3'd7, 3'd2, 3'd1, 1'b1, 8'h2A, 0);

        // Back-to-back: instruction 2 reads the rd written by instruction 1
        exp_ops.push_back(32'h0503);
        exp_wr.push_back({21'h0, 3'd4, 8'h08});
        issue(3'd4, 3'd1, 3'd2, 1'b1, 8'h08, 1);
        exp_ops.push_back(32'h0805);
        exp_wr.push_back({21'h0, 3'd5, 8'h0D});
        issue(3'd5, 3'd4, 3'd1, 1'b1, 8'h0D, 1);

        // R0 as source and destination
`ifdef R0_ZERO_EN
        exp_ops.push_back(32'h0003);
`else
        exp_ops.push_back(32'hAA03);
        exp_wr.push_back({21'h0, 3'd0, 8'h11});
`endif
        issue(3'd0, 3'd0, 3'd2, 1'b1, 8'h11, 2);
        step(4);
        check("r0_wb_busy", 32'(bus.busy), 32'd1);
        step(1);
        check("r0_ready", 32'(bus.instr_ready), 32'd1);

        // alu_done in IDLE is ignored
        stray_done = 1'b1;
        alu_res = 8'hEE;
        step(1);
        stray_done = 1'b0;
        check("stray_busy", 32'(bus.busy), 32'd0);
        check("stray_wdata", 32'(bus.rf_wdata), 32'h11);
        step(5);

        check("ops_drained", 32'(exp_ops.size()), 32'd0);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        check("errs_drained", 32'(exp_err.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
